fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of an async FIFO among NUM_REQ

---
 rtl/fifo_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Shares the single write port of an async FIFO among NUM_REQ requesters in
// the source clock domain. A round-robin pick in IDLE hands the port to one
// requester, which keeps it until it sends a beat marked last or until it has
// sent MAX_BURST beats. Accepted beats pass straight through to the FIFO
// write port with no added latency, throttled by fifo_full_i.
//
// Ports
//   clk_i         source-domain clock (also the FIFO write clock)
//   rst_i         synchronous reset, active-high
//   req_valid_i   per-requester beat valid
//   req_last_i    per-requester last beat of burst
//   req_data_i    packed beats, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   per-requester beat accepted (valid & ready = transfer)
//   fifo_full_i   FIFO full flag
//   fifo_wr_en_o  FIFO write enable
//   fifo_data_o   FIFO write data
//   grant_o       one-hot current owner, 0 when idle
//   busy_o        1 while a requester owns the port

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]      rr_last_q, rr_last_d;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  accept;
    logic                  burst_end;
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    // (base + off) mod NUM_REQ; off never exceeds NUM_REQ, so one
    // conditional subtract is enough and no divider is built.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Unpack the flat data bus so the owner's beat can be selected by index.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pick: scanning from the far end toward rr_last+1 lets the
    // nearest valid requester after the previous owner overwrite the others.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req_valid_i[wrap_idx(rr_last_q, off)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(rr_last_q, off);
            end
        end
    end

    // A beat only moves in GRANT when the owner is valid and the FIFO has
    // room; reset blocks it combinationally so nothing is written that cycle.
    assign accept    = (state_q == GRANT) && req_valid_i[owner_q] && !fifo_full_i && !rst_i;
    assign burst_end = req_last_i[owner_q] || (beat_cnt_q == LAST_BEAT);

    // State register; every piece of arbiter state returns to its reset
    // value so a burst cut by reset is never resumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rr_last_q  <= LAST_IDX;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rr_last_q  <= rr_last_d;
        end
    end

    // Next-state logic. The owner keeps the port through dropped valid and
    // full stalls; only a last beat or the burst limit releases it.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rr_last_d  = rr_last_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (burst_end) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_last_d  = owner_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: only the owner sees ready, and the write data follows the
    // owner's bus directly with zero latency.
    always_comb begin
        req_ready_o = '0;
        fifo_data_o = '0;
        if (state_q == GRANT) begin
            req_ready_o[owner_q] = !fifo_full_i && !rst_i;
            fifo_data_o          = req_data_arr[owner_q];
        end
    end

    assign fifo_wr_en_o = accept;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, 32-bit
// data). A table of per-cycle vectors covers the basic flows, hand-written
// sequences cover burst limit, full stalls and reset mid-burst, and a long
// random run is compared against a behavioural model plus an order
// scoreboard and a starvation monitor.

module tb_fifo_wr_arbiter;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 4;

    logic                          clk_i;
    logic                          rst_i;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_full_i;
    logic                          fifo_wr_en_o;
    logic [DATA_WIDTH-1:0]         fifo_data_o;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          busy_o;

    fifo_wr_arbiter #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .fifo_full_i (fifo_full_i),
        .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_data_o (fifo_data_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] base;
        logic [3:0]  exp_ready;
        logic        exp_wr;
        logic [3:0]  exp_grant;
        logic        exp_busy;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] fifo_q[$];
    logic [31:0] exp4[4];

    // Random-phase state: behavioural model, requester drivers, monitors.
    int          m_owner;
    int          m_beats;
    int          m_last_win;
    int          m_acc;
    int          pend[NUM_REQ];
    int          left[NUM_REQ];
    int          seq[NUM_REQ];
    int          sb_seq[NUM_REQ];
    int          waitg[NUM_REQ];
    logic [3:0]  prev_grant;
    logic [3:0]  prev_valid;
    logic        r_rst;
    logic        r_full;
    logic [3:0]  r_valid;
    logic [3:0]  r_last;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic [31:0] e_data;
    int          w_idx;
    int          id;

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                                input logic full, input logic [31:0] base,
                                input logic [3:0] er, input logic ew, input logic [3:0] eg,
                                input logic eb, input logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.full = full; v.base = base;
        v.exp_ready = er; v.exp_wr = ew; v.exp_grant = eg; v.exp_busy = eb; v.exp_data = ed;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge; requester k sees base+k.
    task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                                 input logic full, input logic [31:0] base);
        @(negedge clk_i);
        rst_i       = rst;
        req_valid_i = valid;
        req_last_i  = last;
        fifo_full_i = full;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data_i[k*DATA_WIDTH +: DATA_WIDTH] = base + 32'(k);
        end
        #1;
    endtask

    task automatic checkOne(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] er, input logic ew,
                               input logic [3:0] eg, input logic eb, input logic [31:0] ed);
        checkOne({name, ".ready"}, 64'(req_ready_o), 64'(er));
        checkOne({name, ".wr_en"}, 64'(fifo_wr_en_o), 64'(ew));
        checkOne({name, ".grant"}, 64'(grant_o), 64'(eg));
        checkOne({name, ".busy"}, 64'(busy_o), 64'(eb));
        checkOne({name, ".data"}, 64'(fifo_data_o), 64'(ed));
    endtask

    task automatic captureWrite();
        if (fifo_wr_en_o === 1'b1) begin
            fifo_q.push_back(fifo_data_o);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        fifo_full_i = 1'b0;
        req_data_i  = '0;

        $display("[TB] reset");
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);

        // Vector table: single-requester burst, rotation over all four,
        // and a full stall on a single-beat burst.
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 32'h00,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'h1, 4'h0, 0, 32'hA0,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'h1, 4'h0, 0, 32'hA0,   4'h1, 1, 4'h1, 1, 32'hA0));
        vecs.push_back(mk(0, 4'h1, 4'h0, 0, 32'hB0,   4'h1, 1, 4'h1, 1, 32'hB0));
        vecs.push_back(mk(0, 4'h1, 4'h1, 0, 32'hC0,   4'h1, 1, 4'h1, 1, 32'hC0));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 32'h00,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(1, 4'hF, 4'hF, 0, 32'h10,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h1, 1, 4'h1, 1, 32'h10));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h2, 1, 4'h2, 1, 32'h11));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h4, 1, 4'h4, 1, 32'h12));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h8, 1, 4'h8, 1, 32'h13));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 32'h10,   4'h1, 1, 4'h1, 1, 32'h10));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 32'h00,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'h4, 4'h4, 0, 32'h20,   4'h0, 0, 4'h0, 0, 32'h00));
        vecs.push_back(mk(0, 4'h4, 4'h4, 1, 32'h20,   4'h0, 0, 4'h4, 1, 32'h22));
        vecs.push_back(mk(0, 4'h4, 4'h4, 0, 32'h20,   4'h4, 1, 4'h4, 1, 32'h22));
        vecs.push_back(mk(0, 4'h0, 4'h0, 0, 32'h00,   4'h0, 0, 4'h0, 0, 32'h00));

        $display("[TB] vector table, %0d rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].base);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_wr,
                        vecs[i].exp_grant, vecs[i].exp_busy, vecs[i].exp_data);
        end

        // Burst limit: requester 2 never asserts last and is cut after
        // MAX_BURST beats; requester 3 then wins over requester 2.
        $display("[TB] burst limit");
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h4, 4'h0, 1'b0, 32'h300);
        checkOutput("t3.idle", 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        for (int b = 0; b < MAX_BURST; b++) begin
            applyStimulus(1'b0, 4'h4, 4'h0, 1'b0, 32'h300 + 32'(b * 16));
            checkOutput($sformatf("t3.beat%0d", b), 4'h4, 1'b1, 4'h4, 1'b1, 32'h302 + 32'(b * 16));
        end
        applyStimulus(1'b0, 4'hC, 4'h0, 1'b0, 32'h380);
        checkOutput("t3.rotate_idle", 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'hC, 4'h8, 1'b0, 32'h380);
        checkOutput("t3.req3_wins", 4'h8, 1'b1, 4'h8, 1'b1, 32'h383);
        applyStimulus(1'b0, 4'h4, 4'h4, 1'b0, 32'h390);
        checkOutput("t3.idle2", 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h4, 4'h4, 1'b0, 32'h390);
        checkOutput("t3.req2_alone", 4'h4, 1'b1, 4'h4, 1'b1, 32'h392);

        // Full stall after beat 1 of requester 1's four-beat burst.
        $display("[TB] full stall");
        fifo_q.delete();
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h2, 4'h0, 1'b0, 32'h400);
        checkOutput("t4.idle", 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h2, 4'h0, 1'b0, 32'h400);
        checkOutput("t4.beat1", 4'h2, 1'b1, 4'h2, 1'b1, 32'h401);
        captureWrite();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'h2, 4'h0, 1'b1, 32'h410);
            checkOutput($sformatf("t4.full%0d", c), 4'h0, 1'b0, 4'h2, 1'b1, 32'h411);
            captureWrite();
        end
        for (int b = 1; b < 4; b++) begin
            applyStimulus(1'b0, 4'h2, (b == 3) ? 4'h2 : 4'h0, 1'b0, 32'h400 + 32'(b * 16));
            checkOutput($sformatf("t4.beat%0d", b + 1), 4'h2, 1'b1, 4'h2, 1'b1, 32'h401 + 32'(b * 16));
            captureWrite();
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("t4.done", 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        exp4[0] = 32'h401; exp4[1] = 32'h411; exp4[2] = 32'h421; exp4[3] = 32'h431;
        checkOne("t4.fifo_count", 64'(fifo_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < fifo_q.size(); i++) begin
            checkOne($sformatf("t4.fifo%0d", i), 64'(fifo_q[i]), 64'(exp4[i]));
        end

        // Reset during beat 2: requester 2 finishes first so the pointer is
        // away from its reset value, then reset must restore requester-0 priority.
        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h4, 4'h4, 1'b0, 32'h500);
        applyStimulus(1'b0, 4'h4, 4'h4, 1'b0, 32'h500);
        checkOutput("t5.req2", 4'h4, 1'b1, 4'h4, 1'b1, 32'h502);
        applyStimulus(1'b0, 4'h1, 4'h0, 1'b0, 32'h510);
        applyStimulus(1'b0, 4'h1, 4'h0, 1'b0, 32'h510);
        checkOutput("t5.beat1", 4'h1, 1'b1, 4'h1, 1'b1, 32'h510);
        applyStimulus(1'b1, 4'h1, 4'h0, 1'b0, 32'h520);
        checkOne("t5.rst_wr_en", 64'(fifo_wr_en_o), 64'd0);
        checkOne("t5.rst_ready", 64'(req_ready_o), 64'd0);
        applyStimulus(1'b0, 4'hA, 4'hA, 1'b0, 32'h530);
        checkOutput("t5.after_rst", 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'hA, 4'hA, 1'b0, 32'h530);
        checkOutput("t5.lowest_wins", 4'h2, 1'b1, 4'h2, 1'b1, 32'h531);

        // Random traffic against the behavioural model.
        $display("[TB] random traffic");
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
        m_owner    = -1;
        m_beats    = 0;
        m_last_win = NUM_REQ - 1;
        for (int k = 0; k < NUM_REQ; k++) begin
            pend[k] = 0; left[k] = 0; seq[k] = 0; sb_seq[k] = 0; waitg[k] = 0;
        end
        prev_grant = '0;
        prev_valid = '0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            r_rst  = ($urandom_range(0, 399) == 0);
            r_full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                r_valid[k] = (pend[k] != 0) && (m_owner != k || $urandom_range(0, 3) != 0);
                r_last[k]  = r_valid[k] ? (left[k] == 1) : 1'($urandom_range(0, 1));
            end
            @(negedge clk_i);
            rst_i       = r_rst;
            req_valid_i = r_valid;
            req_last_i  = r_last;
            fifo_full_i = r_full;
            for (int k = 0; k < NUM_REQ; k++) begin
                req_data_i[k*DATA_WIDTH +: DATA_WIDTH] = {8'(k), 24'(seq[k])};
            end
            #1;

            e_ready = '0; e_wr = 1'b0; e_grant = '0; e_busy = 1'b0; e_data = '0; m_acc = -1;
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                e_busy           = 1'b1;
                e_data           = {8'(m_owner), 24'(seq[m_owner])};
                if (!r_full && !r_rst) begin
                    e_ready[m_owner] = 1'b1;
                    if (r_valid[m_owner]) begin
                        e_wr  = 1'b1;
                        m_acc = m_owner;
                    end
                end
            end
            checkOutput("rand", e_ready, e_wr, e_grant, e_busy, e_data);

            if (fifo_wr_en_o === 1'b1) begin
                checkOne("rand.wr_while_full", 64'(fifo_full_i), 64'd0);
                id = int'(fifo_data_o[31:24]);
                if (id < NUM_REQ) begin
                    checkOne($sformatf("rand.order%0d", id), 64'(fifo_data_o[23:0]), 64'(sb_seq[id]));
                    sb_seq[id]++;
                end else begin
                    checkOne("rand.write_id", 64'(id), 64'(NUM_REQ - 1));
                end
            end

            if (grant_o != '0 && prev_grant == '0) begin
                w_idx = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (grant_o[k]) w_idx = k;
                end
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (k != w_idx && prev_valid[k]) begin
                        waitg[k]++;
                        checkOne($sformatf("rand.starve%0d", k), 64'(waitg[k] <= NUM_REQ - 1), 64'd1);
                    end
                end
                if (w_idx >= 0) waitg[w_idx] = 0;
            end
            prev_grant = grant_o;
            prev_valid = r_valid;

            if (r_rst) begin
                m_owner    = -1;
                m_beats    = 0;
                m_last_win = NUM_REQ - 1;
                for (int k = 0; k < NUM_REQ; k++) waitg[k] = 0;
            end else if (m_owner < 0) begin
                for (int off = 1; off <= NUM_REQ && m_owner < 0; off++) begin
                    if (r_valid[(m_last_win + off) % NUM_REQ]) m_owner = (m_last_win + off) % NUM_REQ;
                end
            end else if (m_acc >= 0) begin
                m_beats++;
                if (r_last[m_owner] || m_beats == MAX_BURST) begin
                    m_last_win = m_owner;
                    m_owner    = -1;
                    m_beats    = 0;
                end
            end

            if (m_acc >= 0) begin
                seq[m_acc]++;
                left[m_acc]--;
                if (left[m_acc] == 0) pend[m_acc] = 0;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pend[k] == 0 && $urandom_range(0, 9) == 0) begin
                    pend[k]  = 1;
                    left[k]  = int'($urandom_range(1, 6));
                    waitg[k] = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
